// File: rtl/id_exe_pipe_reg_if.sv
// ID->EXE handshake bus: valid/ready on both sides plus the decoded payload.
// slave = pipeline register side, master = the ID/EXE neighbours side.
interface id_exe_pipe_reg_if #(
  parameter int WORD_LEN     = 32,
  parameter int REG_ADDR_LEN = 5,
  parameter int EXE_CMD_LEN  = 4
);

  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  logic mem_r_en_in;
  logic mem_w_en_in;
  logic wb_en_in;
  logic br_taken_in;
  logic [EXE_CMD_LEN-1:0]  exe_cmd_in;
  logic [REG_ADDR_LEN-1:0] dest_in;
  logic [REG_ADDR_LEN-1:0] src1_in;
  logic [REG_ADDR_LEN-1:0] src2_in;
  logic [WORD_LEN-1:0]     st_value_in;
  logic [WORD_LEN-1:0]     val1_in;
  logic [WORD_LEN-1:0]     val2_in;
  logic [WORD_LEN-1:0]     pc_in;

  logic mem_r_en;
  logic mem_w_en;
  logic wb_en;
  logic br_taken;
  logic [EXE_CMD_LEN-1:0]  exe_cmd;
  logic [REG_ADDR_LEN-1:0] dest;
  logic [REG_ADDR_LEN-1:0] src1;
  logic [REG_ADDR_LEN-1:0] src2;
  logic [WORD_LEN-1:0]     st_value;
  logic [WORD_LEN-1:0]     val1;
  logic [WORD_LEN-1:0]     val2;
  logic [WORD_LEN-1:0]     pc;

  modport slave (
    input  in_valid,
    output in_ready,
    output out_valid,
    input  out_ready,
    input  mem_r_en_in,
    input  mem_w_en_in,
    input  wb_en_in,
    input  br_taken_in,
    input  exe_cmd_in,
    input  dest_in,
    input  src1_in,
    input  src2_in,
    input  st_value_in,
    input  val1_in,
    input  val2_in,
    input  pc_in,
    output mem_r_en,
    output mem_w_en,
    output wb_en,
    output br_taken,
    output exe_cmd,
    output dest,
    output src1,
    output src2,
    output st_value,
    output val1,
    output val2,
    output pc
  );

  modport master (
    output in_valid,
    input  in_ready,
    input  out_valid,
    output out_ready,
    output mem_r_en_in,
    output mem_w_en_in,
    output wb_en_in,
    output br_taken_in,
    output exe_cmd_in,
    output dest_in,
    output src1_in,
    output src2_in,
    output st_value_in,
    output val1_in,
    output val2_in,
    output pc_in,
    input  mem_r_en,
    input  mem_w_en,
    input  wb_en,
    input  br_taken,
    input  exe_cmd,
    input  dest,
    input  src1,
    input  src2,
    input  st_value,
    input  val1,
    input  val2,
    input  pc
  );

endinterface

// File: rtl/id_exe_pipe_reg.sv
// ID->EXE pipeline register: 2-entry skid buffer (M drives EXE, S is skid),
// flush, gated control enables. Ports: clk, rst (async active-low), flush,
// bus (slave), stall_cnt/flush_cnt. Counters need ID_EXE_PERF_CNT_EN.
module id_exe_pipe_reg #(
  parameter int WORD_LEN     = 32,
  parameter int REG_ADDR_LEN = 5,
  parameter int EXE_CMD_LEN  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  id_exe_pipe_reg_if.slave bus,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef struct packed {
    logic                    mem_r_en;
    logic                    mem_w_en;
    logic                    wb_en;
    logic                    br_taken;
    logic [EXE_CMD_LEN-1:0]  exe_cmd;
    logic [REG_ADDR_LEN-1:0] dest;
    logic [REG_ADDR_LEN-1:0] src1;
    logic [REG_ADDR_LEN-1:0] src2;
    logic [WORD_LEN-1:0]     st_value;
    logic [WORD_LEN-1:0]     val1;
    logic [WORD_LEN-1:0]     val2;
    logic [WORD_LEN-1:0]     pc;
  } id_ex_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  id_ex_t in_pl;
  id_ex_t m_q;
  id_ex_t s_q;

  logic acc;
  logic deq;
  logic ld_m_in;
  logic ld_m_skid;
  logic ld_s;

  always_comb begin
    in_pl          = '0;
    in_pl.mem_r_en = bus.mem_r_en_in;
    in_pl.mem_w_en = bus.mem_w_en_in;
    in_pl.wb_en    = bus.wb_en_in;
    in_pl.br_taken = bus.br_taken_in;
    in_pl.exe_cmd  = bus.exe_cmd_in;
    in_pl.dest     = bus.dest_in;
    in_pl.src1     = bus.src1_in;
    in_pl.src2     = bus.src2_in;
    in_pl.st_value = bus.st_value_in;
    in_pl.val1     = bus.val1_in;
    in_pl.val2     = bus.val2_in;
    in_pl.pc       = bus.pc_in;
  end

  // Ready depends only on occupancy (and reset), never on out_ready.
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.in_ready  = rst & (state_q != TWO);

  // A flushing cycle neither accepts nor delivers.
  assign acc = bus.in_valid & bus.in_ready & ~flush;
  assign deq = bus.out_valid & bus.out_ready & ~flush;

  always_comb begin
    state_d   = state_q;
    ld_m_in   = 1'b0;
    ld_m_skid = 1'b0;
    ld_s      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            ld_m_in = 1'b1;
            state_d = ONE;
          end
        end
        ONE: begin
          unique case (1'b1)
            acc & deq: begin
              ld_m_in = 1'b1;
            end
            acc & ~deq: begin
              ld_s    = 1'b1;
              state_d = TWO;
            end
            ~acc & deq: begin
              state_d = EMPTY;
            end
            default: begin
              state_d = ONE;
            end
          endcase
        end
        TWO: begin
          if (deq) begin
            ld_m_skid = 1'b1;
            state_d   = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // M is always the older entry; S only ever refills M.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q <= '0;
    end else if (ld_m_in) begin
      m_q <= in_pl;
    end else if (ld_m_skid) begin
      m_q <= s_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q <= '0;
    end else if (ld_s) begin
      s_q <= in_pl;
    end
  end

  // Bubbles must never write memory or the register file.
  assign bus.mem_r_en = m_q.mem_r_en & bus.out_valid;
  assign bus.mem_w_en = m_q.mem_w_en & bus.out_valid;
  assign bus.wb_en    = m_q.wb_en & bus.out_valid;
  assign bus.br_taken = m_q.br_taken & bus.out_valid;
  assign bus.exe_cmd  = m_q.exe_cmd;
  assign bus.dest     = m_q.dest;
  assign bus.src1     = m_q.src1;
  assign bus.src2     = m_q.src2;
  assign bus.st_value = m_q.st_value;
  assign bus.val1     = m_q.val1;
  assign bus.val2     = m_q.val2;
  assign bus.pc       = m_q.pc;

`ifdef ID_EXE_PERF_CNT_EN
  logic [15:0] stall_q;
  logic [15:0] flush_q;
  logic        stall_hit;
  logic        flush_hit;

  assign stall_hit = bus.out_valid & ~bus.out_ready;
  assign flush_hit = flush & bus.out_valid;

  // Both counters saturate instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (stall_hit && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_q <= '0;
    end else if (flush_hit && flush_q != 16'hFFFF) begin
      flush_q <= flush_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = 16'h0;
  assign flush_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Bench for id_exe_pipe_reg: directed vector table, hand sequences for
// reset/flush/perf, and random traffic against a 2-deep queue model.
module tb_id_exe_pipe_reg;

`ifdef ID_EXE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic        mr;
    logic        mw;
    logic        wb;
    logic        br;
    logic [3:0]  cmd;
    logic [4:0]  d;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [31:0] st;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] pc;
  } pl_t;

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic        ordy;
    logic        fl;
    logic        e_ov;
    logic        e_ir;
    logic [31:0] e_pc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int checks = 0;
  int errors = 0;

  pl_t  q[$];
  int   m_st = 0;
  int   m_fl = 0;
  vec_t tbl[$];

  id_exe_pipe_reg_if #(
    .WORD_LEN(32), .REG_ADDR_LEN(5), .EXE_CMD_LEN(4)
  ) bus ();

  id_exe_pipe_reg #(
    .WORD_LEN(32), .REG_ADDR_LEN(5), .EXE_CMD_LEN(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .bus(bus),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic rand_pl();
    bus.mem_r_en_in = 1'($urandom);
    bus.mem_w_en_in = 1'($urandom);
    bus.wb_en_in    = 1'($urandom);
    bus.br_taken_in = 1'($urandom);
    bus.exe_cmd_in  = 4'($urandom);
    bus.dest_in     = 5'($urandom);
    bus.src1_in     = 5'($urandom);
    bus.src2_in     = 5'($urandom);
    bus.st_value_in = $urandom;
    bus.val1_in     = $urandom;
    bus.val2_in     = $urandom;
    bus.pc_in       = $urandom;
  endtask

  function automatic pl_t cur_pl();
    pl_t p;
    p.mr  = bus.mem_r_en_in;
    p.mw  = bus.mem_w_en_in;
    p.wb  = bus.wb_en_in;
    p.br  = bus.br_taken_in;
    p.cmd = bus.exe_cmd_in;
    p.d   = bus.dest_in;
    p.s1  = bus.src1_in;
    p.s2  = bus.src2_in;
    p.st  = bus.st_value_in;
    p.v1  = bus.val1_in;
    p.v2  = bus.val2_in;
    p.pc  = bus.pc_in;
    return p;
  endfunction

  // One clock: inputs already driven; model advances as a bounded queue.
  task automatic cycle();
    logic iv;
    logic ordy;
    logic fl;
    pl_t  p;
    int   n;
    iv   = bus.in_valid;
    ordy = bus.out_ready;
    fl   = flush;
    p    = cur_pl();
    n    = q.size();
    @(posedge clk);
    if (n > 0 && !ordy && m_st < 65535) m_st++;
    if (fl) begin
      if (n > 0 && m_fl < 65535) m_fl++;
      q.delete();
    end else begin
      if (n > 0 && ordy) void'(q.pop_front());
      if (iv && n < 2) q.push_back(p);
    end
    @(negedge clk);
  endtask

  task automatic check_model();
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      chk("mem_r_en", 32'(bus.mem_r_en), 32'(q[0].mr));
      chk("mem_w_en", 32'(bus.mem_w_en), 32'(q[0].mw));
      chk("wb_en", 32'(bus.wb_en), 32'(q[0].wb));
      chk("br_taken", 32'(bus.br_taken), 32'(q[0].br));
      chk("exe_cmd", 32'(bus.exe_cmd), 32'(q[0].cmd));
      chk("dest", 32'(bus.dest), 32'(q[0].d));
      chk("src1", 32'(bus.src1), 32'(q[0].s1));
      chk("src2", 32'(bus.src2), 32'(q[0].s2));
      chk("st_value", bus.st_value, q[0].st);
      chk("val1", bus.val1, q[0].v1);
      chk("val2", bus.val2, q[0].v2);
      chk("pc", bus.pc, q[0].pc);
    end else begin
      chk("gated_en", 32'({bus.mem_r_en, bus.mem_w_en,
                           bus.wb_en, bus.br_taken}), 32'd0);
    end
  endtask

  task automatic check_cnts(input string nm);
    chk({nm, "_stall_cnt"}, 32'(stall_cnt), PERF ? 32'(m_st) : 32'd0);
    chk({nm, "_flush_cnt"}, 32'(flush_cnt), PERF ? 32'(m_fl) : 32'd0);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({nm, "_flags"}, 32'({bus.mem_r_en, bus.mem_w_en,
                             bus.wb_en, bus.br_taken}), 32'd0);
    chk({nm, "_regs"}, 32'({bus.exe_cmd, bus.dest,
                            bus.src1, bus.src2}), 32'd0);
    chk({nm, "_words"}, bus.st_value | bus.val1 |
                        bus.val2 | bus.pc, 32'd0);
    chk({nm, "_cnts"}, 32'({stall_cnt, flush_cnt}), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    q.delete();
    m_st = 0;
    m_fl = 0;
    rst = 1'b1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rand_pl();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_all_zero("por");
    rst = 1'b1;
    #1;
    chk("por_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    // Directed vectors: streaming, back-pressure, flush with accept
    for (int i = 0; i < 8; i++)
      tbl.push_back('{1'b1, 32'(4 * i), 1'b1, 1'b0,
                      1'b1, 1'b1, 32'(4 * i)});
    tbl.push_back('{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00});
    tbl.push_back('{1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40});
    tbl.push_back('{1'b1, 32'h44, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40});
    tbl.push_back('{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h44});
    tbl.push_back('{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00});
    tbl.push_back('{1'b1, 32'h50, 1'b0, 1'b0, 1'b1, 1'b1, 32'h50});
    tbl.push_back('{1'b1, 32'h80, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00});
    tbl.push_back('{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00});

    foreach (tbl[i]) begin
      rand_pl();
      bus.in_valid  = tbl[i].iv;
      bus.pc_in     = tbl[i].pc;
      bus.out_ready = tbl[i].ordy;
      flush         = tbl[i].fl;
      cycle();
      chk($sformatf("vec%0d_out_valid", i),
          32'(bus.out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("vec%0d_in_ready", i),
          32'(bus.in_ready), 32'(tbl[i].e_ir));
      if (tbl[i].e_ov)
        chk($sformatf("vec%0d_pc", i), bus.pc, tbl[i].e_pc);
      check_model();
    end
    flush = 1'b0;

    // Random traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      rand_pl();
      bus.in_valid  = ($urandom % 4) != 0;
      bus.out_ready = ($urandom % 3) != 0;
      flush         = ($urandom % 16) == 0;
      cycle();
      check_model();
    end
    flush = 1'b0;
    check_cnts("rand");

    // Async reset with both entries occupied
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    rand_pl();
    cycle();
    rand_pl();
    cycle();
    rand_pl();
    cycle();
    check_model();
    chk("pre_rst_full", 32'(bus.in_ready), 32'd0);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    bus.in_valid = 1'b0;
    q.delete();
    m_st = 0;
    m_fl = 0;
    rst  = 1'b1;
    #1;
    chk("rst_release_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    // Flush while TWO with wb_en and mem_w_en set
    bus.in_valid    = 1'b1;
    bus.out_ready   = 1'b0;
    rand_pl();
    bus.wb_en_in    = 1'b1;
    bus.mem_w_en_in = 1'b1;
    cycle();
    cycle();
    check_model();
    bus.in_valid = 1'b0;
    flush        = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_wb_en", 32'(bus.wb_en), 32'd0);
    chk("flush_mem_w_en", 32'(bus.mem_w_en), 32'd0);
    chk("flush_cnt_one", 32'(flush_cnt), PERF ? 32'd1 : 32'd0);
    check_cnts("flush");

    // Stall counting with one entry held for 5 cycles
    do_reset();
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    rand_pl();
    cycle();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    check_model();
    chk("stall_cnt_5", 32'(stall_cnt), PERF ? 32'd5 : 32'd0);
    check_cnts("perf");
    bus.out_ready = 1'b1;
    cycle();
    check_model();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
